// File: rtl/mem_arbiter_if.sv
// Bundle of requester (inst/data) and unified memory port signals seen by mem_arbiter.
interface mem_arbiter_if #(
  parameter int Xlen = 32,
  parameter int Dlen = 32
);
  localparam int Mlen = Dlen / 8;

  logic            inst_ready_o;
  logic            inst_valid_i;
  logic [Xlen-1:0] inst_addr_i;
  logic [Dlen-1:0] inst_wdata_i;
  logic [Mlen-1:0] inst_wmask_i;
  logic [Dlen-1:0] inst_rdata_o;
  logic            inst_rvalid_o;

  logic            data_ready_o;
  logic            data_valid_i;
  logic [Xlen-1:0] data_addr_i;
  logic [Dlen-1:0] data_wdata_i;
  logic [Mlen-1:0] data_wmask_i;
  logic [Dlen-1:0] data_rdata_o;
  logic            data_rvalid_o;

  logic            mem_ready_i;
  logic            mem_valid_o;
  logic [Xlen-1:0] mem_addr_o;
  logic [Dlen-1:0] mem_wdata_o;
  logic [Mlen-1:0] mem_wmask_o;
  logic [Dlen-1:0] mem_rdata_i;
  logic            mem_rvalid_i;

  logic            overflow_o;

  // Arbiter side
  modport slave (
    output inst_ready_o, inst_rdata_o, inst_rvalid_o,
    input  inst_valid_i, inst_addr_i, inst_wdata_i, inst_wmask_i,
    output data_ready_o, data_rdata_o, data_rvalid_o,
    input  data_valid_i, data_addr_i, data_wdata_i, data_wmask_i,
    input  mem_ready_i, mem_rdata_i, mem_rvalid_i,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output overflow_o
  );

  // Requesters + memory side
  modport master (
    input  inst_ready_o, inst_rdata_o, inst_rvalid_o,
    output inst_valid_i, inst_addr_i, inst_wdata_i, inst_wmask_i,
    input  data_ready_o, data_rdata_o, data_rvalid_o,
    output data_valid_i, data_addr_i, data_wdata_i, data_wmask_i,
    output mem_ready_i, mem_rdata_i, mem_rvalid_i,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  overflow_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin merge of inst/data request ports onto one memory port; an ID FIFO
// remembers the source of each in-flight request so in-order responses get steered back.
module mem_arbiter_idq #(
  parameter int AW = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_push,
  input  logic i_id,
  input  logic i_pop,
  output logic o_head,
  output logic o_full,
  output logic o_empty
);
  localparam int Depth = 1 << AW;
  localparam logic [AW:0] FullCnt = {1'b1, {AW{1'b0}}};

  logic [Depth-1:0] r_ids;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_ids[r_rptr];

  // Pointers wrap naturally; the count separates full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ids   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ids[r_wptr] <= i_id;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module mem_arbiter #(
  parameter int Xlen               = 32,
  parameter int Dlen               = 32,
  parameter int MaxOutstandingLog2 = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);
  localparam int   Mlen    = Dlen / 8;
  localparam logic SrcInst = 1'b0;
  localparam logic SrcData = 1'b1;

  logic            w_any;
  logic            w_both;
  logic            w_gnt;
  logic            w_full;
  logic            w_empty;
  logic            w_head;
  logic            w_fwd;
  logic            w_accept;
  logic            w_rsp;
  logic [Xlen-1:0] w_addr;
  logic [Dlen-1:0] w_wdata;
  logic [Mlen-1:0] w_wmask;
  logic            r_last_grant;
  logic            r_overflow;

  // Grant depends only on the valids and history, never on mem_ready_i.
  assign w_any  = bus.inst_valid_i | bus.data_valid_i;
  assign w_both = bus.inst_valid_i & bus.data_valid_i;
  assign w_gnt  = w_both ? ~r_last_grant : bus.data_valid_i;

  always_comb begin
    w_addr  = bus.inst_addr_i;
    w_wdata = bus.inst_wdata_i;
    w_wmask = '0;
    if (w_gnt == SrcData) begin
      w_addr  = bus.data_addr_i;
      w_wdata = bus.data_wdata_i;
    end
    if (w_any) w_wmask = (w_gnt == SrcData) ? bus.data_wmask_i : bus.inst_wmask_i;
  end

  // Outputs are forced idle while reset is high, independent of the clock.
  assign w_fwd    = w_any && !w_full && !rst_i;
  assign w_accept = w_fwd && bus.mem_ready_i;
  assign w_rsp    = bus.mem_rvalid_i && !w_empty && !rst_i;

  mem_arbiter_idq #(.AW(MaxOutstandingLog2)) u_idq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_accept),
    .i_id    (w_gnt),
    .i_pop   (w_rsp),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.mem_valid_o   = w_fwd;
  assign bus.mem_addr_o    = w_addr;
  assign bus.mem_wdata_o   = w_wdata;
  assign bus.mem_wmask_o   = w_wmask;

  assign bus.inst_ready_o  = w_fwd && (w_gnt == SrcInst) && bus.mem_ready_i;
  assign bus.data_ready_o  = w_fwd && (w_gnt == SrcData) && bus.mem_ready_i;

  assign bus.inst_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o  = bus.mem_rdata_i;
  assign bus.inst_rvalid_o = w_rsp && (w_head == SrcInst);
  assign bus.data_rvalid_o = w_rsp && (w_head == SrcData);
  assign bus.overflow_o    = r_overflow;

  // A response with nothing in flight (including a same-cycle push) is an overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_grant <= SrcInst;
      r_overflow   <= 1'b0;
    end else begin
      if (w_accept) r_last_grant <= w_gnt;
      if (bus.mem_rvalid_i && w_empty) r_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corners, random vs queue model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;

  mem_arbiter_if #(.Xlen(32), .Dlen(32)) bus ();

  mem_arbiter #(.Xlen(32), .Dlen(32), .MaxOutstandingLog2(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of source ids (0 inst, 1 data), last accepted port, sticky overflow.
  int mq[$];
  bit m_last;
  bit m_ovf;
  bit e_accept;
  bit e_gnt;
  bit e_rsp;

  typedef struct packed {
    logic [3:0] in;   // inst_valid, data_valid, mem_ready, mem_rvalid
    logic [5:0] exp;  // mem_valid, inst_ready, data_ready, inst_rvalid, data_rvalid, overflow
  } vec_t;
  vec_t tbl [20];

  task automatic chk1(input string name, input logic act, input logic exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last   = 1'b0;
    m_ovf    = 1'b0;
    e_accept = 1'b0;
    e_gnt    = 1'b0;
    e_rsp    = 1'b0;
  endtask

  task automatic check_cycle();
    bit iv, dv, mr, rv, any, gnt, full, busy;
    logic [3:0] em;
    iv   = bus.inst_valid_i;
    dv   = bus.data_valid_i;
    mr   = bus.mem_ready_i;
    rv   = bus.mem_rvalid_i;
    any  = iv | dv;
    gnt  = (iv && dv) ? !m_last : dv;
    full = (mq.size() == 4);
    busy = (mq.size() != 0);
    chk1("mem_valid", bus.mem_valid_o, any && !full);
    chk1("inst_ready", bus.inst_ready_o, any && !gnt && mr && !full);
    chk1("data_ready", bus.data_ready_o, any && gnt && mr && !full);
    chk1("inst_rvalid", bus.inst_rvalid_o, rv && busy && (mq[0] == 0));
    chk1("data_rvalid", bus.data_rvalid_o, rv && busy && (mq[0] == 1));
    chk1("overflow", bus.overflow_o, m_ovf);
    em = !any ? 4'h0 : (gnt ? bus.data_wmask_i : bus.inst_wmask_i);
    chk32("mem_wmask", 32'(bus.mem_wmask_o), 32'(em));
    if (any && !full) begin
      chk32("mem_addr", bus.mem_addr_o, gnt ? bus.data_addr_i : bus.inst_addr_i);
      chk32("mem_wdata", bus.mem_wdata_o, gnt ? bus.data_wdata_i : bus.inst_wdata_i);
    end
    chk32("inst_rdata", bus.inst_rdata_o, bus.mem_rdata_i);
    chk32("data_rdata", bus.data_rdata_o, bus.mem_rdata_i);
    e_accept = any && !full && mr;
    e_gnt    = gnt;
    e_rsp    = rv;
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_rsp) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_ovf = 1'b1;
    end
    if (e_accept) begin
      mq.push_back(int'(e_gnt));
      m_last = e_gnt;
    end
    @(negedge clk);
  endtask

  task automatic step();
    check_cycle();
    advance();
  endtask

  task automatic idle_inputs();
    bus.inst_valid_i = 1'b0;
    bus.data_valid_i = 1'b0;
    bus.mem_ready_i  = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk1({tag, " mem_valid"}, bus.mem_valid_o, 1'b0);
    chk1({tag, " inst_ready"}, bus.inst_ready_o, 1'b0);
    chk1({tag, " data_ready"}, bus.data_ready_o, 1'b0);
    chk1({tag, " inst_rvalid"}, bus.inst_rvalid_o, 1'b0);
    chk1({tag, " data_rvalid"}, bus.data_rvalid_o, 1'b0);
    chk1({tag, " overflow"}, bus.overflow_o, 1'b0);
  endtask

  initial begin
    tbl[0]  = {4'b1110, 6'b101000};
    tbl[1]  = {4'b1110, 6'b110000};
    tbl[2]  = {4'b1111, 6'b101010};
    tbl[3]  = {4'b1111, 6'b110100};
    tbl[4]  = {4'b1110, 6'b101000};
    tbl[5]  = {4'b1110, 6'b110000};
    tbl[6]  = {4'b1110, 6'b000000};
    tbl[7]  = {4'b1111, 6'b000010};
    tbl[8]  = {4'b1110, 6'b101000};
    tbl[9]  = {4'b0011, 6'b000100};
    tbl[10] = {4'b0011, 6'b000010};
    tbl[11] = {4'b0001, 6'b000100};
    tbl[12] = {4'b0001, 6'b000010};
    tbl[13] = {4'b1100, 6'b100000};
    tbl[14] = {4'b1100, 6'b100000};
    tbl[15] = {4'b1110, 6'b110000};
    tbl[16] = {4'b0111, 6'b101100};
    tbl[17] = {4'b0011, 6'b000010};
    tbl[18] = {4'b0011, 6'b000000};
    tbl[19] = {4'b0000, 6'b000001};

    idle_inputs();
    bus.inst_addr_i  = 32'h0;
    bus.inst_wdata_i = 32'h0;
    bus.inst_wmask_i = 4'h0;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
    bus.data_wmask_i = 4'h0;
    bus.mem_rdata_i  = 32'h0;
    model_reset();

    // Outputs must stay idle under reset even with every input active.
    @(negedge clk);
    bus.inst_valid_i = 1'b1;
    bus.data_valid_i = 1'b1;
    bus.mem_ready_i  = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    #1 check_idle_outputs("reset");
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    // Vector table: round robin, queue full, pop/push overlap, spurious response.
    bus.inst_addr_i  = 32'h0000_0100;
    bus.inst_wdata_i = 32'h1111_1111;
    bus.data_addr_i  = 32'h0000_2000;
    bus.data_wdata_i = 32'h2222_2222;
    bus.data_wmask_i = 4'hF;
    for (int i = 0; i < 20; i++) begin
      {bus.inst_valid_i, bus.data_valid_i, bus.mem_ready_i, bus.mem_rvalid_i} = tbl[i].in;
      bus.mem_rdata_i = 32'hA000_0000 + 32'(i);
      #1;
      chk1($sformatf("tbl%0d mem_valid", i), bus.mem_valid_o, tbl[i].exp[5]);
      chk1($sformatf("tbl%0d inst_ready", i), bus.inst_ready_o, tbl[i].exp[4]);
      chk1($sformatf("tbl%0d data_ready", i), bus.data_ready_o, tbl[i].exp[3]);
      chk1($sformatf("tbl%0d inst_rvalid", i), bus.inst_rvalid_o, tbl[i].exp[2]);
      chk1($sformatf("tbl%0d data_rvalid", i), bus.data_rvalid_o, tbl[i].exp[1]);
      chk1($sformatf("tbl%0d overflow", i), bus.overflow_o, tbl[i].exp[0]);
      step();
    end
    idle_inputs();

    // Inst-only read.
    bus.inst_valid_i = 1'b1;
    bus.inst_addr_i  = 32'h0000_0100;
    bus.inst_wmask_i = 4'h0;
    bus.mem_ready_i  = 1'b1;
    #1;
    chk32("iread addr", bus.mem_addr_o, 32'h0000_0100);
    chk32("iread wmask", 32'(bus.mem_wmask_o), 32'h0);
    step();
    bus.inst_valid_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    chk1("iread rvalid", bus.inst_rvalid_o, 1'b1);
    chk32("iread rdata", bus.inst_rdata_o, 32'hDEAD_BEEF);
    chk1("iread data_rvalid", bus.data_rvalid_o, 1'b0);
    step();
    idle_inputs();

    // Data-port write.
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h0000_2000;
    bus.data_wdata_i = 32'h1234_5678;
    bus.data_wmask_i = 4'hF;
    bus.mem_ready_i  = 1'b1;
    #1;
    chk32("dwrite addr", bus.mem_addr_o, 32'h0000_2000);
    chk32("dwrite wdata", bus.mem_wdata_o, 32'h1234_5678);
    chk32("dwrite wmask", 32'(bus.mem_wmask_o), 32'hF);
    step();
    bus.data_valid_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    #1;
    chk1("dwrite data_rvalid", bus.data_rvalid_o, 1'b1);
    chk1("dwrite inst_rvalid", bus.inst_rvalid_o, 1'b0);
    step();
    idle_inputs();

    // Backpressure: last grant was data, so inst holds the grant through the stall.
    bus.inst_valid_i = 1'b1;
    bus.inst_addr_i  = 32'h0000_0300;
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h0000_0400;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("stall mem_valid", bus.mem_valid_o, 1'b1);
      chk32("stall addr", bus.mem_addr_o, 32'h0000_0300);
      chk1("stall inst_ready", bus.inst_ready_o, 1'b0);
      step();
    end
    bus.mem_ready_i = 1'b1;
    #1;
    chk1("unstall inst_ready", bus.inst_ready_o, 1'b1);
    chk1("unstall data_ready", bus.data_ready_o, 1'b0);
    step();
    bus.inst_valid_i = 1'b0;
    #1;
    chk32("after stall addr", bus.mem_addr_o, 32'h0000_0400);
    step();
    bus.data_valid_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    #1 chk1("stall rsp0 inst", bus.inst_rvalid_o, 1'b1);
    step();
    #1 chk1("stall rsp1 data", bus.data_rvalid_o, 1'b1);
    step();
    idle_inputs();

    // Randomized traffic against the model; requests stay stable until accepted.
    for (int c = 0; c < 400; c++) begin
      if (e_accept && !e_gnt) bus.inst_valid_i = 1'b0;
      if (e_accept && e_gnt)  bus.data_valid_i = 1'b0;
      if (!bus.inst_valid_i && ($urandom % 2 == 0)) begin
        bus.inst_valid_i = 1'b1;
        bus.inst_addr_i  = $urandom;
        bus.inst_wdata_i = $urandom;
        bus.inst_wmask_i = 4'($urandom);
      end
      if (!bus.data_valid_i && ($urandom % 2 == 0)) begin
        bus.data_valid_i = 1'b1;
        bus.data_addr_i  = $urandom;
        bus.data_wdata_i = $urandom;
        bus.data_wmask_i = 4'($urandom);
      end
      bus.mem_ready_i  = ($urandom % 4) != 0;
      bus.mem_rvalid_i = (mq.size() != 0) && ($urandom % 3 == 0);
      bus.mem_rdata_i  = $urandom;
      #1 step();
    end
    idle_inputs();
    for (int k = 0; k < 8 && mq.size() > 0; k++) begin
      bus.mem_rvalid_i = 1'b1;
      #1 step();
    end
    idle_inputs();

    // Two requests in flight, then reset asserted between clock edges.
    bus.inst_valid_i = 1'b1;
    bus.data_valid_i = 1'b1;
    bus.mem_ready_i  = 1'b1;
    #1 step();
    #1 step();
    bus.mem_rvalid_i = 1'b1;
    #2 rst = 1'b1;
    #1 check_idle_outputs("async reset");
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    // Response for a request issued before reset: overflow, no rvalid.
    bus.mem_rvalid_i = 1'b1;
    #1;
    chk1("post-reset inst_rvalid", bus.inst_rvalid_o, 1'b0);
    chk1("post-reset data_rvalid", bus.data_rvalid_o, 1'b0);
    step();
    bus.mem_rvalid_i = 1'b0;
    #1 chk1("post-reset overflow", bus.overflow_o, 1'b1);
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester to one-port memory arbiter that sits directly downstream of the core.
- It merges the core's instruction-fetch port and data port onto a single unified memory port, giving a von Neumann system build.
- It arbitrates requests round-robin and tracks the source of every outstanding request in a small ID queue.
- It routes each in-order memory response back to the requester that issued it.

Parameters:
- Xlen, 32, address width.
- Dlen, 32, data width; mask width is Dlen/8.
- MaxOutstandingLog2, 2, log2 of the maximum number of in-flight requests (default 4).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- inst_ready_o  out  1  instruction request accepted when high with inst_valid_i
- inst_valid_i  in  1  instruction request valid
- inst_addr_i  in  Xlen  instruction request address
- inst_wdata_i  in  Dlen  instruction write data
- inst_wmask_i  in  Dlen/8  instruction byte write mask; 0 means read
- inst_rdata_o  out  Dlen  instruction response data
- inst_rvalid_o  out  1  instruction response valid
- data_ready_o, data_valid_i, data_addr_i, data_wdata_i, data_wmask_i, data_rdata_o, data_rvalid_o  same widths/meaning as inst_*, for the data port
- mem_ready_i  in  1  memory can accept a request
- mem_valid_o  out  1  request to memory
- mem_addr_o  out  Xlen  forwarded request address
- mem_wdata_o  out  Dlen  forwarded write data
- mem_wmask_o  out  Dlen/8  forwarded byte write mask
- mem_rdata_i  in  Dlen  memory response data
- mem_rvalid_i  in  1  memory response valid; exactly one per accepted request, read or write, in order
- overflow_o  out  1  sticky: a response arrived with no outstanding request

Behaviour:
- Handshake:
  - A request transfers when valid && ready in the same cycle.
  - Requesters hold valid, addr, wdata and wmask stable until accepted.
- Reset: asynchronous and active-high, acting on all state regardless of the clock. While rst_i is high and on release:
  - ID queue is empty.
  - last_grant = Inst.
  - overflow_o = 0.
  - mem_valid_o = 0, all ready_o = 0, all rvalid_o = 0.
  - Outputs are held at these values throughout reset.
- Grant logic: combinational from inst_valid_i, data_valid_i and last_grant only. It must never depend on mem_ready_i, so there is no loop through the memory.
  - Only one valid: grant that port.
  - Both valid: grant the port opposite last_grant (round-robin).
  - Neither valid: no grant; mem_valid_o = 0.
- Request forwarding:
  - mem_valid_o = granted valid && !queue_full.
  - mem_addr_o, mem_wdata_o and mem_wmask_o are muxed from the granted port. When there is no grant they are don't-care and mem_wmask_o is driven 0.
  - Granted port's ready_o = mem_ready_i && !queue_full.
  - Non-granted port's ready_o = 0.
- Queue push on acceptance (mem_valid_o && mem_ready_i):
  - Push the source ID (0 = Inst, 1 = Data) into the ID queue.
  - last_grant is updated to the accepted port.
  - last_grant changes only on acceptance, not on grant alone.
- Queue full:
  - No new grant is forwarded when the queue is full, even if a pop happens in the same cycle.
  - There is no same-cycle pop-then-push bypass.
- Response routing (mem_rvalid_i), zero latency:
  - Pop the head ID and assert the matching rvalid_o in the same cycle.
  - Both rdata_o ports are driven from mem_rdata_i unconditionally; only rvalid is steered.
- Simultaneous push and pop in a non-full, non-empty queue: the occupancy count is unchanged and ordering is preserved.
- Push and pop on an empty queue in the same cycle:
  - The response belongs to no request, so it is treated as an overflow.
  - Only the push takes effect.
- Response on an empty queue:
  - No rvalid_o is asserted.
  - overflow_o is set and stays high until reset.
  - The queue stays empty (no underflow wrap).
- Queue pointers: binary, wrapping modulo 2^MaxOutstandingLog2; a separate count or extra pointer bit distinguishes full from empty.
- Reset mid-transaction: outstanding IDs are discarded. Responses that arrive after reset for pre-reset requests set overflow_o.

Test Plan:
- Inst-only read: inst_valid_i=1, inst_addr_i=0x100, mem_ready_i=1, memory returns 0xDEADBEEF next cycle -> mem_addr_o=0x100, mem_wmask_o=0; inst_rvalid_o=1 with inst_rdata_o=0xDEADBEEF; data_rvalid_o stays 0.
- Round-robin contention: both valid every cycle, mem_ready_i=1 -> accepted sequence is Data, Inst, Data, Inst (last_grant=Inst after reset); responses return to ports in the same order.
- Backpressure: both valid, mem_ready_i=0 for 3 cycles, then 1 -> mem_valid_o stays 1 with a stable address, the grant does not toggle during the stall, and exactly one acceptance occurs.
- Queue full: mem_ready_i=1 with no responses for 4 accepts -> 5th request sees ready_o=0 and mem_valid_o=0. Then one mem_rvalid_i -> that cycle still blocked, next cycle the request is accepted.
- Write to data port: data_wmask_i=0xF, data_wdata_i=0x12345678, addr=0x2000 -> fields forwarded unchanged; the write's rvalid response is routed to data_rvalid_o.
- Spurious response and async reset: mem_rvalid_i with an empty queue -> no rvalid_o and overflow_o=1 and held. Assert rst_i between clock edges with 2 requests outstanding -> outputs clear immediately, overflow_o=0, queue empty.
